// File: rtl/led_fade_pkg.sv
// Shared types and helpers for the LED fade driver.
// Holds the channel state encoding and the brightness ceiling helper.
package led_fade_pkg;

   localparam logic [1:0] ST_OFF_ENC     = 2'd0;
   localparam logic [1:0] ST_RISING_ENC  = 2'd1;
   localparam logic [1:0] ST_ON_ENC      = 2'd2;
   localparam logic [1:0] ST_FALLING_ENC = 2'd3;

   typedef enum logic [1:0] {
      OFF     = ST_OFF_ENC,
      RISING  = ST_RISING_ENC,
      ON      = ST_ON_ENC,
      FALLING = ST_FALLING_ENC
   } fade_state_t;

   // Full-scale brightness for a BW-bit level, i.e. 2^BW - 1.
   function automatic int unsigned max_level(input int unsigned bw);
      return (32'd1 << bw) - 32'd1;
   endfunction

endpackage

// File: rtl/led_fade_channel.sv
// One LED channel: on/off request FSM, brightness ramp, duty mapping and
// the registered PWM output flop.
// Optional build macro LED_FADE_GAMMA_EN selects the squared (gamma) duty
// curve; without it duty follows the level linearly and no multiplier exists.
module led_fade_channel
   import led_fade_pkg::*;
#(
   parameter int BW = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          tick,
   input  logic          fade_en,
   input  logic          req,
   input  logic [BW-1:0] pwm_cnt,
   output logic          led_o,
   output logic          active
);

   localparam logic [BW-1:0] MAX_LVL  = BW'(max_level(BW));
   localparam logic [BW-1:0] MAX_M1   = BW'(max_level(BW) - 32'd1);
   localparam logic [BW-1:0] ONE_LVL  = BW'(1);
   localparam logic [BW-1:0] ZERO_LVL = {BW{1'b0}};

   fade_state_t   state_r;
   fade_state_t   state_nxt_s;
   logic [BW-1:0] level_r;
   logic [BW-1:0] level_nxt_s;
   logic [BW-1:0] duty_s;
   logic          led_r;

   // Next state and level; a direction change always wins over a pending step.
   always_comb begin
      state_nxt_s = state_r;
      level_nxt_s = level_r;
      if (!fade_en) begin
         if (req) begin
            state_nxt_s = ON;
            level_nxt_s = MAX_LVL;
         end else begin
            state_nxt_s = OFF;
            level_nxt_s = ZERO_LVL;
         end
      end else begin
         case (state_r)
            OFF: begin
               if (req) state_nxt_s = RISING;
               else     state_nxt_s = OFF;
            end
            RISING: begin
               if (!req) begin
                  state_nxt_s = FALLING;
               end else if (level_r == MAX_LVL) begin
                  state_nxt_s = ON;
               end else if (tick) begin
                  level_nxt_s = level_r + ONE_LVL;
                  if (level_r == MAX_M1) state_nxt_s = ON;
                  else                   state_nxt_s = RISING;
               end else begin
                  state_nxt_s = RISING;
               end
            end
            ON: begin
               if (!req) state_nxt_s = FALLING;
               else      state_nxt_s = ON;
            end
            FALLING: begin
               if (req) begin
                  state_nxt_s = RISING;
               end else if (level_r == ZERO_LVL) begin
                  state_nxt_s = OFF;
               end else if (tick) begin
                  level_nxt_s = level_r - ONE_LVL;
                  if (level_r == ONE_LVL) state_nxt_s = OFF;
                  else                    state_nxt_s = FALLING;
               end else begin
                  state_nxt_s = FALLING;
               end
            end
            default: begin
               state_nxt_s = OFF;
               level_nxt_s = ZERO_LVL;
            end
         endcase
      end
   end

`ifdef LED_FADE_GAMMA_EN
   logic [2*BW-1:0] sq_s;

   // Gamma curve: level squared scaled back to BW bits, full scale pinned.
   always_comb begin
      sq_s = {{BW{1'b0}}, level_r} * {{BW{1'b0}}, level_r};
      if (level_r == MAX_LVL) duty_s = MAX_LVL;
      else                    duty_s = sq_s[2*BW-1:BW];
   end
`else
   // Linear curve: duty is the level itself.
   always_comb begin
      duty_s = level_r;
   end
`endif

   // State, level and PWM output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= OFF;
         level_r <= ZERO_LVL;
         led_r   <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         level_r <= level_nxt_s;
         led_r   <= (pwm_cnt < duty_s);
      end
   end

   assign led_o  = led_r;
   // Reports the state being entered so the top-level busy flop tracks state_r.
   assign active = (state_nxt_s == RISING) || (state_nxt_s == FALLING);

endmodule

// File: rtl/led_fade_driver.sv
// LED fade driver: turns per-LED on/off requests into PWM drive with linear
// brightness ramps. Holds the shared fade-tick prescaler, the free-running
// PWM counter and the busy reduction; per-LED logic lives in led_fade_channel.
// Optional build macro LED_FADE_GAMMA_EN (see led_fade_channel) selects the
// gamma duty curve.
module led_fade_driver
   import led_fade_pkg::*;
#(
   parameter int N_LEDS   = 8,
   parameter int BW       = 8,
   parameter int PRESCALE = 256
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [N_LEDS-1:0] led_req,
   input  logic              fade_en,
   output logic [N_LEDS-1:0] led_o,
   output logic              busy
);

   localparam int              PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0]   PRE_LAST = PW'(PRESCALE - 1);
   localparam logic [PW-1:0]   PRE_ONE  = PW'(1);
   localparam logic [BW-1:0]   PWM_LAST = BW'(max_level(BW) - 32'd1);
   localparam logic [BW-1:0]   PWM_ONE  = BW'(1);

   logic [PW-1:0]     pre_cnt_r;
   logic              tick_s;
   logic [BW-1:0]     pwm_cnt_r;
   logic [N_LEDS-1:0] active_s;
   logic              busy_r;

   assign tick_s = (pre_cnt_r == PRE_LAST);

   // Fade-tick prescaler: counts 0..PRESCALE-1 and wraps.
   always_ff @(posedge clk) begin
      if (reset) begin
         pre_cnt_r <= {PW{1'b0}};
      end else if (tick_s) begin
         pre_cnt_r <= {PW{1'b0}};
      end else begin
         pre_cnt_r <= pre_cnt_r + PRE_ONE;
      end
   end

   // PWM counter: counts 0..MAX-1 so a period is MAX cycles and duty MAX is solid on.
   always_ff @(posedge clk) begin
      if (reset) begin
         pwm_cnt_r <= {BW{1'b0}};
      end else if (pwm_cnt_r == PWM_LAST) begin
         pwm_cnt_r <= {BW{1'b0}};
      end else begin
         pwm_cnt_r <= pwm_cnt_r + PWM_ONE;
      end
   end

   for (genvar g = 0; g < N_LEDS; g++) begin : g_ch
      led_fade_channel #(
         .BW (BW)
      ) u_ch (
         .clk     (clk),
         .reset   (reset),
         .tick    (tick_s),
         .fade_en (fade_en),
         .req     (led_req[g]),
         .pwm_cnt (pwm_cnt_r),
         .led_o   (led_o[g]),
         .active  (active_s[g])
      );
   end

   // Busy flag: any channel ramping in either direction.
   always_ff @(posedge clk) begin
      if (reset) begin
         busy_r <= 1'b0;
      end else begin
         busy_r <= |active_s;
      end
   end

   assign busy = busy_r;

endmodule

// File: tb/tb_led_fade_driver.sv
// Directed bench for led_fade_driver at BW=4 (MAX=15), PRESCALE=4.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_led_fade_driver;

   localparam int N   = 8;
   localparam int BW  = 4;
   localparam int PRE = 4;

   localparam logic [1:0] S_OFF  = 2'd0;
   localparam logic [1:0] S_RIS  = 2'd1;
   localparam logic [1:0] S_ON   = 2'd2;
   localparam logic [1:0] S_FALL = 2'd3;

   logic         clk = 1'b0;
   logic         reset;
   logic [N-1:0] led_req;
   logic         fade_en;
   logic [N-1:0] led_o;
   logic         busy;

   int checks   = 0;
   int failures = 0;

   led_fade_driver #(.N_LEDS(N), .BW(BW), .PRESCALE(PRE)) dut (
      .clk     (clk),
      .reset   (reset),
      .led_req (led_req),
      .fade_en (fade_en),
      .led_o   (led_o),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   logic [BW-1:0] lvl_m [N];
   logic [1:0]    st_m  [N];
   for (genvar g = 0; g < N; g++) begin : g_mon
      assign lvl_m[g] = dut.g_ch[g].u_ch.level_r;
      assign st_m[g]  = dut.g_ch[g].u_ch.state_r;
   end

   function automatic int exp_duty(input int lvl);
`ifdef LED_FADE_GAMMA_EN
      if (lvl == 15) return 15;
      return (lvl * lvl) >> 4;
`else
      return lvl;
`endif
   endfunction

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Wait for channel 0 to reach a level; n = falling edges waited.
   task automatic wait_level(input logic [BW-1:0] target, input int budget,
                             output int n, output bit ok);
      n  = 0;
      ok = 1'b0;
      while (n < budget && !ok) begin
         @(negedge clk);
         n++;
         if (lvl_m[0] == target) ok = 1'b1;
      end
   endtask

   // Freeze channel 0 by flipping req each cycle, count led_o[0] highs over one period.
   task automatic freeze_count(input int expect_hi, input string name);
      int hi;
      hi = 0;
      led_req[0] = 1'b0;
      cyc(1);
      led_req[0] = 1'b1;
      cyc(1);
      for (int k = 0; k < 15; k++) begin
         led_req[0] = ~led_req[0];
         @(negedge clk);
         if (led_o[0]) hi++;
      end
      checks++;
      if (hi !== expect_hi) begin
         failures++;
         $display("FAIL %s: high cycles got=%0d exp=%0d", name, hi, expect_hi);
      end
      led_req[0] = 1'b1;
   endtask

   task automatic test_reset;
      int bad;
      reset = 1'b1; led_req = '0; fade_en = 1'b1;
      cyc(3);
      checks++;
      if (led_o !== 8'h00 || busy !== 1'b0 || lvl_m[0] !== 4'd0 || st_m[0] !== S_OFF) begin
         failures++;
         $display("FAIL reset_state: led_o=%h busy=%b lvl=%0d st=%0d exp 00/0/0/0",
                  led_o, busy, lvl_m[0], st_m[0]);
      end
      reset = 1'b0;
      bad = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (led_o !== 8'h00 || busy !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL idle: %0d cycles with led_o or busy set, exp 0", bad);
      end
   endtask

   task automatic test_ramp_up;
      int  n;
      bit  ok;
      int  bad;
      led_req = 8'h01;
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || st_m[0] !== S_RIS || lvl_m[0] !== 4'd0) begin
         failures++;
         $display("FAIL ramp_start: busy=%b st=%0d lvl=%0d exp 1/1/0", busy, st_m[0], lvl_m[0]);
      end
      wait_level(4'd15, 80, n, ok);
      n = n + 1;
      checks++;
      if (!ok || n < 58 || n > 63) begin
         failures++;
         $display("FAIL ramp_time: reached=%b cycles=%0d exp 58..63", ok, n);
      end
      checks++;
      if (st_m[0] !== S_ON) begin
         failures++;
         $display("FAIL ramp_on_state: st=%0d exp %0d", st_m[0], S_ON);
      end
      cyc(2);
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL ramp_busy_clear: busy=%b exp 0", busy);
      end
      bad = 0;
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         if (led_o[0] !== 1'b1) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL full_on: %0d low cycles exp 0", bad);
      end
   endtask

   task automatic test_reversal;
      int n;
      bit ok;
      fade_en = 1'b0; led_req = 8'h00;
      cyc(1);
      fade_en = 1'b1; led_req = 8'h01;
      wait_level(4'd7, 60, n, ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL rev_reach7: level=%0d exp 7", lvl_m[0]);
      end
      led_req = 8'h00;
      @(negedge clk);
      checks++;
      if (st_m[0] !== S_FALL || lvl_m[0] !== 4'd7) begin
         failures++;
         $display("FAIL rev_turn: st=%0d lvl=%0d exp %0d/7", st_m[0], lvl_m[0], S_FALL);
      end
      wait_level(4'd0, 40, n, ok);
      checks++;
      if (!ok || n < 25 || n > 31) begin
         failures++;
         $display("FAIL rev_time: reached=%b cycles=%0d exp 25..31", ok, n);
      end
      checks++;
      if (st_m[0] !== S_OFF || busy !== 1'b0) begin
         failures++;
         $display("FAIL rev_off: st=%0d busy=%b exp %0d/0", st_m[0], busy, S_OFF);
      end
   endtask

   task automatic test_duty;
      int n;
      bit ok;
      fade_en = 1'b1; led_req = 8'h01;
      wait_level(4'd5, 40, n, ok);
      freeze_count(exp_duty(5), "duty_lvl5");
      checks++;
      if (lvl_m[0] !== 4'd5 || busy !== 1'b1) begin
         failures++;
         $display("FAIL duty_frozen: lvl=%0d busy=%b exp 5/1", lvl_m[0], busy);
      end
      wait_level(4'd8, 40, n, ok);
      freeze_count(exp_duty(8), "duty_lvl8");
      wait_level(4'd15, 60, n, ok);
      cyc(2);
      freeze_count(exp_duty(15), "duty_lvl15");
   endtask

   task automatic test_bypass;
      logic [N-1:0] pat;
      logic [BW-1:0] el;
      int bad;
      fade_en = 1'b1; led_req = 8'hFF;
      cyc(6);
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL byp_busy_pre: busy=%b exp 1", busy);
      end
      pat = 8'hA5;
      fade_en = 1'b0; led_req = pat;
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         el = pat[i] ? 4'd15 : 4'd0;
         checks++;
         if (lvl_m[i] !== el) begin
            failures++;
            $display("FAIL byp_level[%0d]: got=%0d exp=%0d", i, lvl_m[i], el);
         end
      end
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL byp_busy: busy=%b exp 0", busy);
      end
      @(negedge clk);
      bad = 0;
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         if (led_o !== pat) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL byp_led: %0d cycles led_o!=%h last=%h", bad, pat, led_o);
      end
   endtask

   task automatic test_reset_mid;
      int bad;
      fade_en = 1'b1; led_req = 8'h0F;
      cyc(10);
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL rst_mid_busy_pre: busy=%b exp 1", busy);
      end
      reset = 1'b1;
      @(negedge clk);
      bad = 0;
      for (int i = 0; i < N; i++) begin
         if (lvl_m[i] !== 4'd0 || st_m[i] !== S_OFF) bad++;
      end
      checks++;
      if (led_o !== 8'h00 || busy !== 1'b0 || bad != 0) begin
         failures++;
         $display("FAIL rst_mid: led_o=%h busy=%b bad_channels=%0d exp 00/0/0", led_o, busy, bad);
      end
      reset = 1'b0; led_req = 8'h00;
      cyc(10);
      checks++;
      if (led_o !== 8'h00 || busy !== 1'b0 || lvl_m[1] !== 4'd0) begin
         failures++;
         $display("FAIL rst_no_resume: led_o=%h busy=%b lvl1=%0d exp 00/0/0", led_o, busy, lvl_m[1]);
      end
   endtask

   initial begin
      reset = 1'b1; led_req = '0; fade_en = 1'b1;
      test_reset();
      test_ramp_up();
      test_reversal();
      test_duty();
      test_bypass();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
